// File: rtl/demux_1x8_framer.sv
// demux_1x8_framer: steer a serial word stream back onto eight parallel lanes A..H
//
// Parameters:
//   WIDTH  bits per lane / serial word
//   CNT_W  width of the completed-frame counter (wraps)
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   din           serial data word
//   din_valid     din is accepted this cycle
//   flush         synchronous abort of the partial frame (wins over din_valid)
//   slot          lane the next accepted word goes to (0=A .. 7=H)
//   o_a..o_h      published lanes, updated together once per frame
//   frame_valid   one-cycle pulse: o_a..o_h just updated
//   frame_count   number of completed frames
//   frame_parity  XOR of all published lane bits (only with DEMUX_PARITY_EN)
//
// Optional feature macro: DEMUX_PARITY_EN adds the frame_parity output.
module demux_1x8_framer #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             flush,
    output logic [2:0]       slot,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b,
    output logic [WIDTH-1:0] o_c,
    output logic [WIDTH-1:0] o_d,
    output logic [WIDTH-1:0] o_e,
    output logic [WIDTH-1:0] o_f,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_h,
    output logic             frame_valid,
`ifdef DEMUX_PARITY_EN
    output logic             frame_parity,
`endif
    output logic [CNT_W-1:0] frame_count
);
    typedef enum logic {FILL, LAST} state_t;
    state_t           state;
    logic [WIDTH-1:0] shadow [8];
    logic [WIDTH-1:0] lanes  [8];
    assign o_a = lanes[0];
    assign o_b = lanes[1];
    assign o_c = lanes[2];
    assign o_d = lanes[3];
    assign o_e = lanes[4];
    assign o_f = lanes[5];
    assign o_g = lanes[6];
    assign o_h = lanes[7];
`ifdef DEMUX_PARITY_EN
    // Parity of the frame being published: lanes A..G from the shadow bank, H straight from din.
    logic pub_parity;
    always_comb begin
        pub_parity = ^din;
        for (int i = 0; i < 7; i++) pub_parity = pub_parity ^ (^shadow[i]);
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            slot        <= 3'd0;
            frame_valid <= 1'b0;
            frame_count <= '0;
`ifdef DEMUX_PARITY_EN
            frame_parity <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                lanes[i]  <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            if (flush) begin
                state <= FILL;
                slot  <= 3'd0;
            end else if (din_valid) begin
                shadow[slot] <= din;
                if (state == LAST) begin
                    // Last word bypasses the shadow bank so the frame publishes on this edge.
                    state       <= FILL;
                    slot        <= 3'd0;
                    frame_valid <= 1'b1;
                    frame_count <= frame_count + CNT_W'(1);
                    for (int i = 0; i < 7; i++) lanes[i] <= shadow[i];
                    lanes[7] <= din;
`ifdef DEMUX_PARITY_EN
                    frame_parity <= pub_parity;
`endif
                end else begin
                    state <= (slot == 3'd6) ? LAST : FILL;
                    slot  <= slot + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_demux_1x8_framer.sv
// tb_demux_1x8_framer: self-checking bench for demux_1x8_framer against a queue-based frame model
module tb_demux_1x8_framer;
    localparam int W = 4;
    localparam int CW = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] din = '0;
    logic din_valid = 1'b0;
    logic flush = 1'b0;
    logic [2:0] slot;
    logic [W-1:0] o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h;
    logic frame_valid;
    logic [CW-1:0] frame_count;
`ifdef DEMUX_PARITY_EN
    logic frame_parity;
`endif
    logic [W-1:0] lanes [8];
    assign lanes[0] = o_a;
    assign lanes[1] = o_b;
    assign lanes[2] = o_c;
    assign lanes[3] = o_d;
    assign lanes[4] = o_e;
    assign lanes[5] = o_f;
    assign lanes[6] = o_g;
    assign lanes[7] = o_h;

    demux_1x8_framer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .flush(flush),
        .slot(slot),
        .o_a(o_a), .o_b(o_b), .o_c(o_c), .o_d(o_d),
        .o_e(o_e), .o_f(o_f), .o_g(o_g), .o_h(o_h),
        .frame_valid(frame_valid),
`ifdef DEMUX_PARITY_EN
        .frame_parity(frame_parity),
`endif
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;

    // Reference model: words of the open frame, last published frame, counters.
    logic [W-1:0] part [$];
    logic [W-1:0] exp_lane [8];
    int exp_cnt = 0;
    logic exp_fv = 1'b0;

    function automatic logic exp_parity();
        logic p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ (^exp_lane[i]);
        return p;
    endfunction

    task automatic model_clear();
        part.delete();
        for (int i = 0; i < 8; i++) exp_lane[i] = '0;
        exp_cnt = 0;
        exp_fv = 1'b0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, return 1 time unit later.
    task automatic step(input logic v, input logic [W-1:0] d, input logic f);
        din_valid = v;
        din = d;
        flush = f;
        @(posedge clk);
        exp_fv = 1'b0;
        if (f) part.delete();
        else if (v) begin
            part.push_back(d);
            if (part.size() == 8) begin
                for (int i = 0; i < 8; i++) exp_lane[i] = part[i];
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                exp_fv = 1'b1;
                part.delete();
            end
        end
        #1;
        din_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (slot !== 3'd0) begin fails++; $display("FAIL reset_slot got %0d want 0", slot); end
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_fv got %b want 0", frame_valid); end
        checks++; if (frame_count !== '0) begin fails++; $display("FAIL reset_cnt got %0d want 0", frame_count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (lanes[i] !== '0) begin fails++; $display("FAIL reset_lane%0d got %0h want 0", i, lanes[i]); end
        end
`ifdef DEMUX_PARITY_EN
        checks++; if (frame_parity !== 1'b0) begin fails++; $display("FAIL reset_parity got %b want 0", frame_parity); end
`endif
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'(i % 2), 1'b0);
            checks++; if (frame_valid !== (i == 7)) begin fails++; $display("FAIL stream_fv word%0d got %b want %b", i, frame_valid, i == 7); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (lanes[i] !== W'(i % 2)) begin fails++; $display("FAIL stream_lane%0d got %0h want %0h", i, lanes[i], i % 2); end
        end
        checks++; if (frame_count !== CW'(1)) begin fails++; $display("FAIL stream_cnt got %0d want 1", frame_count); end
        checks++; if (slot !== 3'd0) begin fails++; $display("FAIL stream_slot got %0d want 0", slot); end
        step(1'b0, '0, 1'b0);
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL stream_pulse_len got %b want 0", frame_valid); end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'(i % 2), 1'b0);
            if (frame_valid) pulses++;
            step(1'b0, W'(3), 1'b0);
            if (frame_valid) pulses++;
            checks++; if (slot !== 3'((i + 1) % 8)) begin fails++; $display("FAIL gap_slot_hold got %0d want %0d", slot, (i + 1) % 8); end
        end
        checks++; if (pulses != 1) begin fails++; $display("FAIL gap_pulses got %0d want 1", pulses); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (lanes[i] !== W'(i % 2)) begin fails++; $display("FAIL gap_lane%0d got %0h want %0h", i, lanes[i], i % 2); end
        end
        checks++; if (frame_count !== CW'(2)) begin fails++; $display("FAIL gap_cnt got %0d want 2", frame_count); end
    endtask

    task automatic test_flush_partial();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, {W{1'b1}}, 1'b0);
            checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL fl5_fv got %b want 0", frame_valid); end
        end
        step(1'b0, '0, 1'b1);
        checks++; if (slot !== 3'd0) begin fails++; $display("FAIL fl5_slot got %0d want 0", slot); end
        checks++; if (lanes[1] !== W'(1) || lanes[0] !== '0) begin fails++; $display("FAIL fl5_hold got %0h/%0h want 0/1", lanes[0], lanes[1]); end
        checks++; if (frame_count !== CW'(2)) begin fails++; $display("FAIL fl5_cnt got %0d want 2", frame_count); end
        for (int i = 0; i < 8; i++) step(1'b1, '0, 1'b0);
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL fl8_fv got %b want 1", frame_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (lanes[i] !== '0) begin fails++; $display("FAIL fl8_lane%0d got %0h want 0", i, lanes[i]); end
        end
        checks++; if (frame_count !== CW'(3)) begin fails++; $display("FAIL fl8_cnt got %0d want 3", frame_count); end
    endtask

    task automatic test_flush_at_last();
        for (int i = 0; i < 7; i++) step(1'b1, W'(5), 1'b0);
        checks++; if (slot !== 3'd7) begin fails++; $display("FAIL fll_slot7 got %0d want 7", slot); end
        step(1'b1, W'(9), 1'b1);
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL fll_fv got %b want 0", frame_valid); end
        checks++; if (slot !== 3'd0) begin fails++; $display("FAIL fll_slot got %0d want 0", slot); end
        checks++; if (o_h !== '0 || o_a !== '0) begin fails++; $display("FAIL fll_lanes got %0h/%0h want 0/0", o_a, o_h); end
        checks++; if (frame_count !== CW'(3)) begin fails++; $display("FAIL fll_cnt got %0d want 3", frame_count); end
        step(1'b0, '0, 1'b0);
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL fll_late_fv got %b want 0", frame_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w [8];
        int pulses = 0;
        do_reset();
        for (int k = 0; k < 32; k++) begin
            w[k % 8] = W'($urandom);
            step(1'b1, w[k % 8], 1'b0);
            checks++; if (frame_valid !== (k % 8 == 7)) begin fails++; $display("FAIL b2b_fv cycle%0d got %b want %b", k, frame_valid, k % 8 == 7); end
            if (k % 8 == 7) begin
                pulses++;
                checks++; if (frame_count !== CW'((k / 8 + 1) % 4)) begin fails++; $display("FAIL b2b_cnt got %0d want %0d", frame_count, (k / 8 + 1) % 4); end
                for (int i = 0; i < 8; i++) begin
                    checks++; if (lanes[i] !== w[i]) begin fails++; $display("FAIL b2b_lane%0d got %0h want %0h", i, lanes[i], w[i]); end
                end
            end
        end
        checks++; if (pulses != 4) begin fails++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w [8];
        for (int i = 0; i < 8; i++) step(1'b1, W'(i + 3), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, W'(7), 1'b0);
        checks++; if (slot !== 3'd3) begin fails++; $display("FAIL ar_slot3 got %0d want 3", slot); end
        #2 rst = 1'b1;
        #1;
        checks++; if (slot !== 3'd0 || frame_count !== '0 || frame_valid !== 1'b0) begin fails++; $display("FAIL ar_ctrl got slot=%0d cnt=%0d fv=%b want 0", slot, frame_count, frame_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (lanes[i] !== '0) begin fails++; $display("FAIL ar_lane%0d got %0h want 0", i, lanes[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            w[i] = W'($urandom);
            step(1'b1, w[i], 1'b0);
        end
        checks++; if (frame_valid !== 1'b1 || frame_count !== CW'(1)) begin fails++; $display("FAIL ar_clean got fv=%b cnt=%0d want 1/1", frame_valid, frame_count); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (lanes[i] !== w[i]) begin fails++; $display("FAIL ar_lane_clean%0d got %0h want %0h", i, lanes[i], w[i]); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(99) < 70, W'($urandom), $urandom_range(99) < 4);
            checks++;
            if (frame_valid !== exp_fv || frame_count !== CW'(exp_cnt) || slot !== 3'(part.size())) begin
                fails++;
                $display("FAIL rnd_ctrl cycle%0d got fv=%b cnt=%0d slot=%0d want fv=%b cnt=%0d slot=%0d",
                         k, frame_valid, frame_count, slot, exp_fv, exp_cnt, part.size());
            end
            for (int i = 0; i < 8; i++) begin
                checks++; if (lanes[i] !== exp_lane[i]) begin fails++; $display("FAIL rnd_lane%0d cycle%0d got %0h want %0h", i, k, lanes[i], exp_lane[i]); end
            end
`ifdef DEMUX_PARITY_EN
            checks++; if (frame_parity !== exp_parity()) begin fails++; $display("FAIL rnd_parity cycle%0d got %b want %b", k, frame_parity, exp_parity()); end
`endif
        end
    endtask

`ifdef DEMUX_PARITY_EN
    task automatic test_parity();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0) ? W'(1) : W'(0), 1'b0);
        checks++; if (frame_parity !== 1'b1) begin fails++; $display("FAIL par_one got %b want 1", frame_parity); end
        step(1'b1, {W{1'b1}}, 1'b0);
        step(1'b0, '0, 1'b1);
        checks++; if (frame_parity !== 1'b1) begin fails++; $display("FAIL par_flush got %b want 1", frame_parity); end
        for (int i = 0; i < 8; i++) step(1'b1, {W{1'b1}}, 1'b0);
        checks++; if (frame_parity !== 1'b0) begin fails++; $display("FAIL par_ones got %b want 0", frame_parity); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_gaps();
        test_flush_partial();
        test_flush_at_last();
        test_back_to_back();
        test_async_reset();
        test_random();
`ifdef DEMUX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
